day_night_sequencer: RTL and testbench

//  Per-frame day/night cycle generator in the pixel-clock domain, directly upstream of the star-field layer.

---
 rtl/day_night_sequencer_pkg.sv | 31 +++
 rtl/day_night_sequencer_frame_tick_timer.sv | 36 +++
 rtl/day_night_sequencer.sv | 110 +++++++++++
 tb/tb_day_night_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/day_night_sequencer_pkg.sv
// Shared day/night cycle definitions: cycle_state encodings and the default
// phase thresholds, so the star-field and background layers agree on them.
package day_night_sequencer_pkg;

   typedef enum logic [1:0] {
      NIGHT_HOLD = 2'd0,
      ADVANCE_AM = 2'd1,
      DAY_HOLD   = 2'd2,
      ADVANCE_PM = 2'd3
   } cycle_state_t;

   localparam int unsigned PHASE_W        = 8;
   localparam int unsigned FRAME_CNT_W    = 16;
   localparam int unsigned BRIGHT_W       = 4;
   localparam int unsigned PHASE_NOON_DEF = 136;
   localparam int unsigned NIGHT_LO_DEF   = 64;
   localparam int unsigned NIGHT_HI_DEF   = 208;

   // Night when the phase is outside the [lo, hi] daylight window.
   function automatic logic night_of(input logic [PHASE_W-1:0] phase,
                                     input logic [PHASE_W-1:0] lo,
                                     input logic [PHASE_W-1:0] hi);
      return (phase < lo) || (phase > hi);
   endfunction

   // Triangle brightness: rises over the first half of the phase, falls over the second.
   function automatic logic [BRIGHT_W-1:0] bright_of(input logic [PHASE_W-1:0] phase);
      return phase[7] ? ~phase[6:3] : phase[6:3];
   endfunction

endpackage

// File: rtl/day_night_sequencer_frame_tick_timer.sv
// frame_tick_timer: counts enabled frames and pulses on terminal count N-1,
// wrapping back to 0 on that same frame. N = 0 behaves like N = 1.
// Ports:
//   clk, rst : clock, async active-high reset
//   en       : count this cycle (frame pulse already folded in)
//   clear    : force the count back to 0
//   tick_c   : combinational terminal pulse (en && count == N-1)
module frame_tick_timer #(
   parameter int unsigned N = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clear,
   output logic tick_c
);

   localparam int unsigned CNT_W = (N < 1) ? 1 : $clog2(N + 1);
   localparam int unsigned TC    = (N == 0) ? 0 : N - 1;

   logic [CNT_W-1:0] cnt;

   assign tick_c = en && (cnt == CNT_W'(TC));

   // Counter: wraps on terminal count, holds when disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || tick_c) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/day_night_sequencer.sv
// day_night_sequencer: per-frame day/night phase generator for the star-field
// and background layers. Advances only on the frame pulse; all outputs are
// registered and change together one clk_pix after the pulse.
// Ports:
//   clk_pix, rst : pixel clock, async active-high reset
//   frame        : single-cycle start-of-frame pulse
//   pause        : freeze the cycle (frame_count keeps running)
//   fade_level   : 8-bit cycle phase (0 = midnight)
//   frame_count  : 16-bit frames since reset
//   is_night     : phase outside the daylight window
//   brightness   : 4-bit triangle sky brightness
//   cycle_state  : NIGHT_HOLD / ADVANCE_AM / DAY_HOLD / ADVANCE_PM
module day_night_sequencer
   import day_night_sequencer_pkg::*;
#(
   parameter int unsigned STEP_FRAMES = 4,
   parameter int unsigned HOLD_FRAMES = 120,
   parameter int unsigned PHASE_NOON  = PHASE_NOON_DEF,
   parameter int unsigned NIGHT_LO    = NIGHT_LO_DEF,
   parameter int unsigned NIGHT_HI    = NIGHT_HI_DEF
) (
   input  logic                   clk_pix,
   input  logic                   rst,
   input  logic                   frame,
   input  logic                   pause,
   output logic [PHASE_W-1:0]     fade_level,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   is_night,
   output logic [BRIGHT_W-1:0]    brightness,
   output logic [1:0]             cycle_state
);

   cycle_state_t       state;
   cycle_state_t       state_nxt;
   logic [PHASE_W-1:0] fade_nxt;
   logic [PHASE_W-1:0] fade_inc;
   logic               run_c;
   logic               hold_en_c;
   logic               step_en_c;
   logic               hold_clr_c;
   logic               hold_tick_c;
   logic               step_tick_c;

   // Timer enables depend only on registered state, keeping the timer
   // terminal pulses free of any loop through the next-state logic.
   assign run_c      = frame && !pause;
   assign hold_en_c  = run_c && ((state == NIGHT_HOLD) || (state == DAY_HOLD));
   assign step_en_c  = run_c && ((state == ADVANCE_AM) || (state == ADVANCE_PM));
   assign hold_clr_c = step_en_c;
   assign fade_inc   = fade_level + PHASE_W'(1);

   frame_tick_timer #(.N(HOLD_FRAMES)) u_hold_timer (
      .clk    (clk_pix),
      .rst    (rst),
      .en     (hold_en_c),
      .clear  (hold_clr_c),
      .tick_c (hold_tick_c)
   );

   frame_tick_timer #(.N(STEP_FRAMES)) u_step_timer (
      .clk    (clk_pix),
      .rst    (rst),
      .en     (step_en_c),
      .clear  (1'b0),
      .tick_c (step_tick_c)
   );

   // Next-state and next-phase logic.
   always_comb begin
      state_nxt = state;
      fade_nxt  = fade_level;
      unique case (state)
         NIGHT_HOLD: if (hold_tick_c) state_nxt = ADVANCE_AM;
         DAY_HOLD:   if (hold_tick_c) state_nxt = ADVANCE_PM;
         ADVANCE_AM: begin
            if (step_tick_c) begin
               fade_nxt = fade_inc;
               if (fade_inc == PHASE_W'(PHASE_NOON)) state_nxt = DAY_HOLD;
            end
         end
         ADVANCE_PM: begin
            if (step_tick_c) begin
               fade_nxt = fade_inc;
               if (fade_inc == '0) state_nxt = NIGHT_HOLD;
            end
         end
         default: state_nxt = NIGHT_HOLD;
      endcase
   end

   // State, phase and derived outputs update together on each frame.
   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         state       <= NIGHT_HOLD;
         fade_level  <= '0;
         frame_count <= '0;
         is_night    <= 1'b1;
         brightness  <= '0;
      end else if (frame) begin
         state       <= state_nxt;
         fade_level  <= fade_nxt;
         frame_count <= frame_count + FRAME_CNT_W'(1);
         is_night    <= night_of(fade_nxt, PHASE_W'(NIGHT_LO), PHASE_W'(NIGHT_HI));
         brightness  <= bright_of(fade_nxt);
      end
   end

   assign cycle_state = 2'(state);

endmodule

// File: tb/tb_day_night_sequencer.sv
// Directed bench for day_night_sequencer with STEP_FRAMES=2, HOLD_FRAMES=3.
// Cycle: 3 hold frames, then 2 frames per phase step.
module tb_day_night_sequencer;

   logic        clk_pix;
   logic        rst;
   logic        frame;
   logic        pause;
   logic [7:0]  fade_level;
   logic [15:0] frame_count;
   logic        is_night;
   logic [3:0]  brightness;
   logic [1:0]  cycle_state;

   int checks;
   int fails;

   day_night_sequencer #(
      .STEP_FRAMES (2),
      .HOLD_FRAMES (3)
   ) dut (
      .clk_pix     (clk_pix),
      .rst         (rst),
      .frame       (frame),
      .pause       (pause),
      .fade_level  (fade_level),
      .frame_count (frame_count),
      .is_night    (is_night),
      .brightness  (brightness),
      .cycle_state (cycle_state)
   );

   initial clk_pix = 1'b0;
   always #5 clk_pix = ~clk_pix;

   task automatic do_reset();
      frame = 1'b0;
      pause = 1'b0;
      rst   = 1'b1;
      repeat (2) @(negedge clk_pix);
      rst = 1'b0;
      @(negedge clk_pix);
   endtask

   // n single-cycle frame pulses, one every two clocks; ends on a negedge.
   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame = 1'b1;
         @(negedge clk_pix);
         frame = 1'b0;
         @(negedge clk_pix);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (fade_level !== 8'd0) begin fails++; $display("FAIL reset_fade got %0d exp 0", fade_level); end
      checks++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_fc got %0d exp 0", frame_count); end
      checks++; if (is_night !== 1'b1) begin fails++; $display("FAIL reset_night got %0b exp 1", is_night); end
      checks++; if (brightness !== 4'd0) begin fails++; $display("FAIL reset_bright got %0d exp 0", brightness); end
      checks++; if (cycle_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", cycle_state); end
   endtask

   task automatic test_hold_exit();
      do_reset();
      run_frames(2);
      checks++; if (cycle_state !== 2'd0) begin fails++; $display("FAIL hold_f2_state got %0d exp 0", cycle_state); end
      run_frames(1);
      checks++; if (cycle_state !== 2'd1) begin fails++; $display("FAIL hold_f3_state got %0d exp 1", cycle_state); end
      checks++; if (fade_level !== 8'd0) begin fails++; $display("FAIL hold_f3_fade got %0d exp 0", fade_level); end
      run_frames(1);
      checks++; if (fade_level !== 8'd0) begin fails++; $display("FAIL step_f1_fade got %0d exp 0", fade_level); end
      // Second step frame: phase moves, visible one clock after the pulse.
      frame = 1'b1;
      @(negedge clk_pix);
      frame = 1'b0;
      checks++; if (fade_level !== 8'd1) begin fails++; $display("FAIL step_f2_fade got %0d exp 1", fade_level); end
      checks++; if (frame_count !== 16'd5) begin fails++; $display("FAIL step_f2_fc got %0d exp 5", frame_count); end
      @(negedge clk_pix);
   endtask

   task automatic test_full_cycle();
      do_reset();
      run_frames(129);
      checks++; if (fade_level !== 8'd63) begin fails++; $display("FAIL fade63 got %0d exp 63", fade_level); end
      checks++; if (is_night !== 1'b1) begin fails++; $display("FAIL night63 got %0b exp 1", is_night); end
      checks++; if (brightness !== 4'd7) begin fails++; $display("FAIL bright63 got %0d exp 7", brightness); end
      checks++; if (frame_count !== 16'd129) begin fails++; $display("FAIL fc129 got %0d exp 129", frame_count); end
      run_frames(2);
      checks++; if (fade_level !== 8'd64) begin fails++; $display("FAIL fade64 got %0d exp 64", fade_level); end
      checks++; if (is_night !== 1'b0) begin fails++; $display("FAIL night64 got %0b exp 0", is_night); end
      checks++; if (brightness !== 4'd8) begin fails++; $display("FAIL bright64 got %0d exp 8", brightness); end
      run_frames(144);
      checks++; if (fade_level !== 8'd136) begin fails++; $display("FAIL fade136 got %0d exp 136", fade_level); end
      checks++; if (cycle_state !== 2'd2) begin fails++; $display("FAIL noon_state got %0d exp 2", cycle_state); end
      checks++; if (brightness !== 4'd14) begin fails++; $display("FAIL bright136 got %0d exp 14", brightness); end
      run_frames(2);
      checks++; if (cycle_state !== 2'd2) begin fails++; $display("FAIL dayhold2_state got %0d exp 2", cycle_state); end
      run_frames(1);
      checks++; if (cycle_state !== 2'd3) begin fails++; $display("FAIL pm_state got %0d exp 3", cycle_state); end
      checks++; if (fade_level !== 8'd136) begin fails++; $display("FAIL pm_fade got %0d exp 136", fade_level); end
      run_frames(144);
      checks++; if (fade_level !== 8'd208) begin fails++; $display("FAIL fade208 got %0d exp 208", fade_level); end
      checks++; if (is_night !== 1'b0) begin fails++; $display("FAIL night208 got %0b exp 0", is_night); end
      run_frames(2);
      checks++; if (is_night !== 1'b1) begin fails++; $display("FAIL night209 got %0b exp 1", is_night); end
      run_frames(92);
      checks++; if (fade_level !== 8'd255) begin fails++; $display("FAIL fade255 got %0d exp 255", fade_level); end
      checks++; if (brightness !== 4'd0) begin fails++; $display("FAIL bright255 got %0d exp 0", brightness); end
      run_frames(1);
      checks++; if (cycle_state !== 2'd3) begin fails++; $display("FAIL pm255_state got %0d exp 3", cycle_state); end
      run_frames(1);
      checks++; if (fade_level !== 8'd0) begin fails++; $display("FAIL wrap_fade got %0d exp 0", fade_level); end
      checks++; if (cycle_state !== 2'd0) begin fails++; $display("FAIL wrap_state got %0d exp 0", cycle_state); end
      checks++; if (is_night !== 1'b1) begin fails++; $display("FAIL wrap_night got %0b exp 1", is_night); end
      checks++; if (frame_count !== 16'd518) begin fails++; $display("FAIL cycle_fc got %0d exp 518", frame_count); end
   endtask

   task automatic test_pause();
      do_reset();
      run_frames(14);
      checks++; if (fade_level !== 8'd5) begin fails++; $display("FAIL pre_pause_fade got %0d exp 5", fade_level); end
      pause = 1'b1;
      run_frames(10);
      checks++; if (fade_level !== 8'd5) begin fails++; $display("FAIL pause_fade got %0d exp 5", fade_level); end
      checks++; if (cycle_state !== 2'd1) begin fails++; $display("FAIL pause_state got %0d exp 1", cycle_state); end
      checks++; if (frame_count !== 16'd24) begin fails++; $display("FAIL pause_fc got %0d exp 24", frame_count); end
      pause = 1'b0;
      // Step counter was parked at 1, so one more frame completes the step.
      run_frames(1);
      checks++; if (fade_level !== 8'd6) begin fails++; $display("FAIL unpause_fade got %0d exp 6", fade_level); end
      checks++; if (frame_count !== 16'd25) begin fails++; $display("FAIL unpause_fc got %0d exp 25", frame_count); end
   endtask

   task automatic test_reset_mid_advance();
      do_reset();
      run_frames(103);
      checks++; if (fade_level !== 8'd50) begin fails++; $display("FAIL mid_fade got %0d exp 50", fade_level); end
      checks++; if (brightness !== 4'd6) begin fails++; $display("FAIL mid_bright got %0d exp 6", brightness); end
      #2 rst = 1'b1;
      #1;
      checks++; if (fade_level !== 8'd0) begin fails++; $display("FAIL async_fade got %0d exp 0", fade_level); end
      checks++; if (frame_count !== 16'd0) begin fails++; $display("FAIL async_fc got %0d exp 0", frame_count); end
      checks++; if (cycle_state !== 2'd0) begin fails++; $display("FAIL async_state got %0d exp 0", cycle_state); end
      checks++; if (brightness !== 4'd0) begin fails++; $display("FAIL async_bright got %0d exp 0", brightness); end
      checks++; if (is_night !== 1'b1) begin fails++; $display("FAIL async_night got %0b exp 1", is_night); end
      @(negedge clk_pix);
      rst = 1'b0;
      @(negedge clk_pix);
   endtask

   task automatic test_frame_wrap();
      do_reset();
      // Frame held high: every cycle is a frame.
      frame = 1'b1;
      repeat (65536) @(negedge clk_pix);
      frame = 1'b0;
      checks++; if (frame_count !== 16'd0) begin fails++; $display("FAIL fc_wrap got %0d exp 0", frame_count); end
      // 65536 mod 518 = 268 frames into a cycle: (268-3)/2 = 132.
      checks++; if (fade_level !== 8'd132) begin fails++; $display("FAIL wrap_phase got %0d exp 132", fade_level); end
      repeat (1000) @(negedge clk_pix);
      checks++; if (frame_count !== 16'd0) begin fails++; $display("FAIL idle_fc got %0d exp 0", frame_count); end
      checks++; if (fade_level !== 8'd132) begin fails++; $display("FAIL idle_fade got %0d exp 132", fade_level); end
      checks++; if (cycle_state !== 2'd1) begin fails++; $display("FAIL idle_state got %0d exp 1", cycle_state); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst    = 1'b1;
      frame  = 1'b0;
      pause  = 1'b0;
      test_reset();
      test_hold_exit();
      test_full_cycle();
      test_pause();
      test_reset_mid_advance();
      test_frame_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
